// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// Arbitration is either fixed (sel) or round-robin starting at ptr.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  logic             load_en;
  logic             granted;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid || out_ready;

  // The round-robin scan runs downwards so the last hit is the first channel at or after ptr.
  always_comb begin
    int idx;
    idx     = 0;
    granted = 1'b0;
    grant   = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          granted = 1'b1;
          grant   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[idx]) begin
          granted = 1'b1;
          grant   = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst_n && load_en && granted;
      end
    end
  end

  assign ptr_next = (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;

  // A loadable register with no grant drains to empty but keeps the stale word and channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (granted) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr with a queue-based scoreboard
// fed by a behavioural arbitration model.
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = $clog2(N);

  typedef struct {
    logic [WIDTH-1:0] data;
    int               ch;
  } word_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SEL_W-1:0]   sel = '0;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SEL_W-1:0]   out_ch;

  int    checks = 0;
  int    failures = 0;
  bit    checking = 1'b0;
  word_t sb[$];
  int    m_ptr = 0;
  bit    m_full = 1'b0;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; holds the inputs for the given number of cycles.
  task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                               input logic r, input int cycles, input bit fixed_data);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++)
      in_data[i*WIDTH +: WIDTH] = fixed_data ? WIDTH'(8'h10 + i) : WIDTH'($urandom);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: decides this cycle's grant from the arbitration rules.
  function automatic int modelGrant();
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Monitor: compares the presented output word against the scoreboard front.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
        checkOutput("out_ch", 32'(out_ch), 32'(sb[0].ch));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Model step runs after the monitor so the pop precedes the next push.
  always @(negedge clk) begin
    #1;
    if (checking) begin
      bit         load;
      int         g;
      logic [N-1:0] exp_rdy;
      word_t      w;
      load    = !m_full || out_ready;
      g       = load ? modelGrant() : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (load) begin
        if (g >= 0) begin
          w.data = in_data[g*WIDTH +: WIDTH];
          w.ch   = g;
          sb.push_back(w);
          m_full = 1'b1;
          m_ptr  = (g + 1) % N;
        end else begin
          m_full = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_ch", 32'(out_ch), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;

    // Fixed select, single channel.
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1, 1, 1'b0);
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    applyStimulus(1'b0, 2'd2, 4'b0000, 1'b1, 2, 1'b0);

    // Round-robin with every channel valid.
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 8, 1'b1);

    // Backpressure holding a word.
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1, 1, 1'b1);
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b0, 3, 1'b1);
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1, 2, 1'b1);

    // ptr at 3 with only ch0/ch1 valid, then drain.
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'b0011, 1'b1, 2, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 2, 1'b0);

    // Fixed select on an idle channel, then switch to round-robin.
    applyStimulus(1'b0, 2'd1, 4'b1101, 1'b1, 2, 1'b0);
    applyStimulus(1'b1, 2'd1, 4'b1101, 1'b1, 2, 1'b0);

    for (int n = 0; n < 300; n++)
      applyStimulus(($urandom_range(3) != 0), SEL_W'($urandom), N'($urandom),
                    ($urandom_range(3) != 0), 1, 1'b0);

    // Asynchronous reset in the middle of a burst.
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 3, 1'b0);
    #1;
    checkOutput("pre_reset_valid", 32'(out_valid), 32'(sb.size() != 0));
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_out_data", 32'(out_data), 32'd0);
    checkOutput("async_out_ch", 32'(out_ch), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    m_ptr = 0;
    m_full = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("held_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    checking = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 6, 1'b1);
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 2, 1'b0);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
